// File: rtl/demortl_dma_chunk_ctrl.sv
// demortl_dma_chunk_ctrl: chunked DMA copy sequencer (read chunk to buffer, write it back).
// Optional status on debug when DEMORTL_DMA_DEBUG_EN is defined.
module demortl_dma_chunk_ctrl #(
   parameter int CHUNK_WORDS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] conf_info_tx_size,
   input  logic [31:0] conf_info_rx_size,
   input  logic        conf_done,
   output logic        dma_read_ctrl_valid,
   input  logic        dma_read_ctrl_ready,
   output logic [31:0] dma_read_ctrl_data_index,
   output logic [31:0] dma_read_ctrl_data_length,
   output logic [2:0]  dma_read_ctrl_data_size,
   input  logic        dma_read_chnl_valid,
   input  logic [31:0] dma_read_chnl_data,
   output logic        dma_read_chnl_ready,
   output logic        dma_write_ctrl_valid,
   input  logic        dma_write_ctrl_ready,
   output logic [31:0] dma_write_ctrl_data_index,
   output logic [31:0] dma_write_ctrl_data_length,
   output logic [2:0]  dma_write_ctrl_data_size,
   output logic        dma_write_chnl_valid,
   output logic [31:0] dma_write_chnl_data,
   input  logic        dma_write_chnl_ready,
   output logic        acc_done,
   output logic [31:0] debug
);
   localparam int CW = $clog2(CHUNK_WORDS) + 1;
   localparam logic [31:0] CHUNK = 32'(CHUNK_WORDS);
   typedef enum logic [2:0] {
      IDLE = 3'd0, RD_REQ = 3'd1, RD_DATA = 3'd2, WR_REQ = 3'd3, WR_DATA = 3'd4, DONE = 3'd5
   } state_t;
   state_t state_q, state_d;
   logic [31:0] rem_q, dst_q, src_q, rem_nxt, len_src;
   logic [CW-1:0] len_q, len_d, rx_cnt_q, tx_cnt_q;
   logic [31:0] mem_q [CHUNK_WORDS];
   logic acc_done_q, start, rd_beat, wr_beat, wr_last;
   assign start   = state_q == IDLE && conf_done;
   assign rd_beat = state_q == RD_DATA && rx_cnt_q != len_q && dma_read_chnl_valid;
   assign wr_beat = state_q == WR_DATA && dma_write_chnl_ready;
   assign wr_last = wr_beat && tx_cnt_q == len_q - CW'(1);
   assign rem_nxt = rem_q - 32'(len_q);
   // next chunk length comes from the fresh size on start, else from what remains after this chunk
   assign len_src = start ? conf_info_tx_size : rem_nxt;
   assign len_d   = len_src >= CHUNK ? CHUNK[CW-1:0] : len_src[CW-1:0];
   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (conf_done) state_d = conf_info_tx_size == 32'd0 ? DONE : RD_REQ;
         RD_REQ:  if (dma_read_ctrl_ready) state_d = RD_DATA;
         RD_DATA: if (rx_cnt_q == len_q) state_d = WR_REQ;
         WR_REQ:  if (dma_write_ctrl_ready) state_d = WR_DATA;
         WR_DATA: if (wr_last) state_d = rem_nxt == 32'd0 ? DONE : RD_REQ;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      dma_read_ctrl_valid        = state_q == RD_REQ;
      dma_read_ctrl_data_index   = src_q;
      dma_read_ctrl_data_length  = 32'(len_q);
      dma_read_ctrl_data_size    = 3'b010;
      dma_read_chnl_ready        = state_q == RD_DATA && rx_cnt_q != len_q;
      dma_write_ctrl_valid       = state_q == WR_REQ;
      dma_write_ctrl_data_index  = dst_q + src_q;
      dma_write_ctrl_data_length = 32'(len_q);
      dma_write_ctrl_data_size   = 3'b010;
      dma_write_chnl_valid       = state_q == WR_DATA;
      dma_write_chnl_data        = state_q == WR_DATA ? mem_q[tx_cnt_q[CW-2:0]] : 32'd0;
      acc_done                   = acc_done_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rem_q      <= '0;
         dst_q      <= '0;
         src_q      <= '0;
         len_q      <= '0;
         rx_cnt_q   <= '0;
         tx_cnt_q   <= '0;
         acc_done_q <= 1'b0;
      end else begin
         acc_done_q <= state_q == DONE;
         if (start) begin
            rem_q <= conf_info_tx_size;
            dst_q <= conf_info_rx_size;
            src_q <= '0;
         end
         if (state_d == RD_REQ && state_q != RD_REQ) len_q <= len_d;
         if (rd_beat) rx_cnt_q <= rx_cnt_q + CW'(1);
         if (wr_beat) tx_cnt_q <= tx_cnt_q + CW'(1);
         if (wr_last) begin
            rem_q    <= rem_nxt;
            src_q    <= src_q + 32'(len_q);
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
         end
      end
   always_ff @(posedge clk)
      if (rd_beat) mem_q[rx_cnt_q[CW-2:0]] <= dma_read_chnl_data;
`ifdef DEMORTL_DMA_DEBUG_EN
   logic [15:0] chunks_q;
   always_ff @(posedge clk or posedge rst)
      if (rst)          chunks_q <= '0;
      else if (start)   chunks_q <= '0;
      else if (wr_last) chunks_q <= chunks_q + 16'd1;
   assign debug = {chunks_q, 8'd0, 5'd0, 3'(state_q)};
`else
   assign debug = 32'd0;
`endif
endmodule

// File: tb/tb_demortl_dma_chunk_ctrl.sv
// tb_demortl_dma_chunk_ctrl: randomized DMA partner plus transaction-level copy model.
module tb_demortl_dma_chunk_ctrl;
   localparam int C = 16;
   logic clk = 1'b0, rst = 1'b1;
   logic [31:0] tx_size = '0, rx_size = '0;
   logic conf_done = 1'b0;
   logic rd_cv, rd_cr = 1'b0, rd_dv = 1'b0, rd_dr;
   logic [31:0] rd_idx, rd_len, rd_data = '0;
   logic [2:0] rd_sz, wr_sz;
   logic wr_cv, wr_cr = 1'b0, wr_dv, wr_dr = 1'b0;
   logic [31:0] wr_idx, wr_len, wr_data;
   logic done;
   logic [31:0] debug;

   demortl_dma_chunk_ctrl #(.CHUNK_WORDS(C)) dut (
      .clk(clk), .rst(rst),
      .conf_info_tx_size(tx_size), .conf_info_rx_size(rx_size), .conf_done(conf_done),
      .dma_read_ctrl_valid(rd_cv), .dma_read_ctrl_ready(rd_cr),
      .dma_read_ctrl_data_index(rd_idx), .dma_read_ctrl_data_length(rd_len),
      .dma_read_ctrl_data_size(rd_sz),
      .dma_read_chnl_valid(rd_dv), .dma_read_chnl_data(rd_data), .dma_read_chnl_ready(rd_dr),
      .dma_write_ctrl_valid(wr_cv), .dma_write_ctrl_ready(wr_cr),
      .dma_write_ctrl_data_index(wr_idx), .dma_write_ctrl_data_length(wr_len),
      .dma_write_ctrl_data_size(wr_sz),
      .dma_write_chnl_valid(wr_dv), .dma_write_chnl_data(wr_data), .dma_write_chnl_ready(wr_dr),
      .acc_done(done), .debug(debug)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   bit bp = 1'b0;
   logic [31:0] src_mem [64];
   logic [31:0] q_rd_idx [$], q_rd_len [$], q_wr_idx [$], q_wr_len [$], q_wd [$];
   int done_cnt = 0, viol = 0, ovl = 0, ctrl_seen = 0;
   bit rs = 1'b0, ws = 1'b0, ds = 1'b0;
   logic [31:0] rs_idx, rs_len, ws_idx, ws_len, ds_data, rbase = '0;
   int rbeat = 0;
   int cur_tx, cur_rx;

   // DMA partner: decide inputs for the coming edge and log the handshakes that edge will complete
   always @(negedge clk) begin
      if (rd_cv && wr_cv) ovl++;
      if (rd_cv || wr_cv) ctrl_seen++;
      if (done) done_cnt++;
      rd_cr = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_cv) begin
         if (rs && (rd_idx !== rs_idx || rd_len !== rs_len)) viol++;
         if (rd_cr) begin
            q_rd_idx.push_back(rd_idx);
            q_rd_len.push_back(rd_len);
            rbase = rd_idx;
            rbeat = 0;
         end
         rs = !rd_cr; rs_idx = rd_idx; rs_len = rd_len;
      end else begin
         if (rs) viol++;
         rs = 1'b0;
      end
      wr_cr = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wr_cv) begin
         if (ws && (wr_idx !== ws_idx || wr_len !== ws_len)) viol++;
         if (wr_cr) begin
            q_wr_idx.push_back(wr_idx);
            q_wr_len.push_back(wr_len);
         end
         ws = !wr_cr; ws_idx = wr_idx; ws_len = wr_len;
      end else begin
         if (ws) viol++;
         ws = 1'b0;
      end
      rd_dv = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_data = src_mem[(rbase + 32'(rbeat)) % 64];
      if (rd_dv && rd_dr) rbeat++;
      wr_dr = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wr_dv) begin
         if (ds && wr_data !== ds_data) viol++;
         if (wr_dr) q_wd.push_back(wr_data);
         ds = !wr_dr; ds_data = wr_data;
      end else begin
         if (ds) viol++;
         ds = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      q_rd_idx.delete(); q_rd_len.delete(); q_wr_idx.delete(); q_wr_len.delete(); q_wd.delete();
      done_cnt = 0; viol = 0; ovl = 0; ctrl_seen = 0;
      rs = 1'b0; ws = 1'b0; ds = 1'b0;
   endtask

   task automatic start_copy(input int tx, input int rx);
      clear_logs();
      for (int i = 0; i < 64; i++) src_mem[i] = $urandom;
      cur_tx = tx; cur_rx = rx;
      tx_size = tx; rx_size = rx;
      @(negedge clk) conf_done = 1'b1;
      @(negedge clk) conf_done = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (done_cnt == 0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk("done_timeout", 32'(done_cnt != 0), 32'd1);
      repeat (10) @(negedge clk);
   endtask

   // expected transfer list: consecutive chunks of at most C words, write offset mirrors read offset
   task automatic check_copy(input string tag);
      int nch = 0;
      for (int off = 0; off < cur_tx; off += (cur_tx - off < C ? cur_tx - off : C)) begin
         int len = cur_tx - off < C ? cur_tx - off : C;
         chk({tag, "_rd_idx"}, nch < q_rd_idx.size() ? q_rd_idx[nch] : 32'hDEADBEEF, 32'(off));
         chk({tag, "_rd_len"}, nch < q_rd_len.size() ? q_rd_len[nch] : 32'hDEADBEEF, 32'(len));
         chk({tag, "_wr_idx"}, nch < q_wr_idx.size() ? q_wr_idx[nch] : 32'hDEADBEEF,
             32'(cur_rx) + 32'(off));
         chk({tag, "_wr_len"}, nch < q_wr_len.size() ? q_wr_len[nch] : 32'hDEADBEEF, 32'(len));
         nch++;
      end
      chk({tag, "_n_rd"}, 32'(q_rd_idx.size()), 32'(nch));
      chk({tag, "_n_wr"}, 32'(q_wr_idx.size()), 32'(nch));
      chk({tag, "_n_data"}, 32'(q_wd.size()), 32'(cur_tx));
      for (int i = 0; i < cur_tx; i++)
         chk({tag, "_data"}, i < q_wd.size() ? q_wd[i] : 32'hDEADBEEF, src_mem[i]);
      chk({tag, "_stable"}, 32'(viol), 32'd0);
      chk({tag, "_overlap"}, 32'(ovl), 32'd0);
      chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("rst_valids", {28'd0, rd_cv, rd_dr, wr_cv, wr_dv}, 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rd_idx", rd_idx, 32'd0);
      chk("rst_wr_len", wr_len, 32'd0);
      chk("rst_sizes", {26'd0, rd_sz, wr_sz}, {26'd0, 3'b010, 3'b010});
      rst = 1'b0;
      repeat (2) @(negedge clk);

      bp = 1'b0;
      start_copy(5, 100);
      wait_done();
      check_copy("t5");

      start_copy(40, 1000);
      wait_done();
      check_copy("t40");
`ifdef DEMORTL_DMA_DEBUG_EN
      chk("dbg_chunks", {16'd0, debug[31:16]}, 32'd3);
      chk("dbg_state", {29'd0, debug[2:0]}, 32'd0);
`else
      chk("dbg_off", debug, 32'd0);
`endif

      clear_logs();
      tx_size = 0; rx_size = 7;
      @(negedge clk) conf_done = 1'b1;
      @(negedge clk) conf_done = 1'b0;
      chk("tx0_done_c1", 32'(done), 32'd0);
      @(negedge clk);
      chk("tx0_done_c2", 32'(done), 32'd1);
      @(negedge clk);
      chk("tx0_done_c3", 32'(done), 32'd0);
      repeat (5) @(negedge clk);
      chk("tx0_ctrl", 32'(ctrl_seen), 32'd0);
      chk("tx0_pulses", 32'(done_cnt), 32'd1);

      bp = 1'b1;
      start_copy(37, $urandom);
      wait_done();
      check_copy("bp37");
      start_copy(20, 32'hFFFF_FFF8);
      wait_done();
      check_copy("wrap");
      for (int k = 0; k < 3; k++) begin
         start_copy($urandom_range(1, 50), $urandom);
         wait_done();
         check_copy("rnd");
      end

      // async reset in the middle of the second chunk's read data phase
      bp = 1'b0;
      start_copy(40, 300);
      n = 0;
      while (!(q_rd_idx.size() == 2 && rbeat >= 3 && rd_dr) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("rst_reach", 32'(n < 2000), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_valids", {28'd0, rd_cv, rd_dr, wr_cv, wr_dv}, 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_idx", rd_idx | wr_idx, 32'd0);
      chk("arst_len", rd_len | wr_len, 32'd0);
      chk("arst_wdata", wr_data, 32'd0);
      chk("arst_debug", debug, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_logs();
      repeat (4) @(negedge clk);
      chk("post_rst_idle", 32'(ctrl_seen + done_cnt), 32'd0);
      start_copy(40, 500);
      wait_done();
      check_copy("after_rst");

      // second conf_done while writing must not restart or add a pulse
      bp = 1'b1;
      start_copy(20, 64);
      n = 0;
      while (!wr_dv && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("wr_reach", 32'(wr_dv), 32'd1);
      conf_done = 1'b1;
      @(negedge clk) conf_done = 1'b0;
      wait_done();
      check_copy("ignore_conf");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
